// File: rtl/femto_pkg.sv
// Shared constants for the femtoRV32 counter/timer blocks.
package femto_pkg;
   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DOWN  = 1'b0;
   localparam int   CSR_CNT_W = 64;
   localparam int   TMR_CNT_W = 32;
endpackage

// File: rtl/tff_counter_bit.sv
// Single toggle flip-flop: async active-low reset, sync clear > sync load > toggle.
// Latency 1 clock; no backpressure.
module tff_bit (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_d,
   input  logic i_t,
   output logic o_q
);
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_q <= 1'b0;
      else if (i_clr)  r_q <= 1'b0;
      else if (i_load) r_q <= i_d;
      else if (i_t)    r_q <= ~r_q;
   end

   assign o_q = r_q;
endmodule

// File: rtl/tff_counter.sv
// Up/down counter from per-bit toggle enables, with prescaler, wrap/saturate, tc pulse, sticky ovf.
// Latency 1 clock from tick to new q; no backpressure (en gates progress).
module tff_counter
   import femto_pkg::*;
#(
   parameter int WIDTH    = TMR_CNT_W,
   parameter int PRESCALE = 1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);
   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0]    r_pre;
   logic             r_tc;
   logic             r_ovf;
   logic             w_sync;
   logic             w_tick;
   logic             w_up;
   logic             w_term;
   logic             w_hold;
   logic [WIDTH:0]   w_ones;
   logic [WIDTH:0]   w_zeros;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_q;

   assign w_sync = clr | load;
   assign w_tick = en & (r_pre == PRE_MAX);
   assign w_up   = (up == CNT_UP);

   // w_ones[i] / w_zeros[i]: bits [i-1:0] all 1 / all 0; index WIDTH is the terminal detect.
   always_comb begin
      w_ones     = '0;
      w_zeros    = '0;
      w_ones[0]  = 1'b1;
      w_zeros[0] = 1'b1;
      for (int i = 1; i <= WIDTH; i++) begin
         w_ones[i]  = w_ones[i-1]  &  w_q[i-1];
         w_zeros[i] = w_zeros[i-1] & ~w_q[i-1];
      end
   end

   assign w_term = w_up ? w_ones[WIDTH] : w_zeros[WIDTH];
   assign w_hold = SATURATE & w_term;

   always_comb begin
      w_t = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_t[i] = w_tick & ~w_hold & (w_up ? w_ones[i] : w_zeros[i]);
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      tff_bit u_bit (
         .i_clk   (clk),
         .i_rst_n (rst),
         .i_clr   (clr),
         .i_load  (load),
         .i_d     (load_val[g]),
         .i_t     (w_t[g]),
         .o_q     (w_q[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_sync) begin
         r_pre <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (en) r_pre <= w_tick ? '0 : r_pre + PW'(1);
         r_tc <= w_tick & w_term;
         if (w_tick & w_term) r_ovf <= 1'b1;
      end
   end

   assign q   = w_q;
   assign tc  = r_tc;
   assign ovf = r_ovf;
endmodule
